// File: rtl/mvu_job_scheduler.sv
// mvu_job_scheduler: in-order job queue in front of the MVU array.
// Jobs are popped head-of-line when their target MVU is idle, the MVU gets a
// one-cycle start pulse, and its irq rising edge is turned into a tagged
// completion that stays queued until the consumer accepts it.
module mvu_job_scheduler #(
    parameter int NMVU  = 8,
    parameter int DEPTH = 4,
    parameter int TAGW  = 8,
    localparam int MIDW = (NMVU > 1) ? $clog2(NMVU) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            job_valid,
    output logic            job_ready,
    input  logic [MIDW-1:0] job_mvu,
    input  logic [TAGW-1:0] job_tag,
    input  logic            flush,
    output logic [NMVU-1:0] mvu_start,
    input  logic [NMVU-1:0] mvu_irq,
    output logic [NMVU-1:0] mvu_busy,
    output logic            done_valid,
    input  logic            done_ready,
    output logic [MIDW-1:0] done_mvu,
    output logic [TAGW-1:0] done_tag,
    output logic            err_badid,
    output logic            err_spurious
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);
    localparam logic [MIDW:0] MVU_LIMIT = (MIDW + 1)'(NMVU);

    // job storage and per-MVU tag of the job currently running there
    logic [MIDW-1:0] fifo_mvu [DEPTH];
    logic [TAGW-1:0] fifo_tag [DEPTH];
    logic [TAGW-1:0] tag_r    [NMVU];

    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic [AW:0]     count_next;
    logic [NMVU-1:0] busy_reg;
    logic [NMVU-1:0] busy_next;
    logic [NMVU-1:0] pending_reg;
    logic [NMVU-1:0] pending_next;
    logic [NMVU-1:0] irq_q_reg;

    logic [MIDW-1:0] head_mvu;
    logic [TAGW-1:0] head_tag;
    logic            id_ok;
    logic            job_acc;
    logic            push;
    logic            pop;
    logic            hs;
    logic            load;
    logic            sel_valid;
    logic [MIDW-1:0] sel_idx;
    logic [NMVU-1:0] irq_edge;
    logic [NMVU-1:0] start_vec;
    logic [NMVU-1:0] hs_vec;
    logic [NMVU-1:0] load_vec;

    assign head_mvu = fifo_mvu[rd_ptr_reg];
    assign head_tag = fifo_tag[rd_ptr_reg];
    assign id_ok    = ({1'b0, job_mvu} < MVU_LIMIT);
    assign job_acc  = job_valid & job_ready;
    // a flushed cycle neither keeps the incoming job nor dispatches
    assign push     = job_acc & id_ok & ~flush;
    assign pop      = (count_reg != '0) & ~busy_reg[head_mvu] & ~flush;
    assign hs       = done_valid & done_ready;
    assign irq_edge = mvu_irq & ~irq_q_reg;
    assign mvu_busy = busy_reg;
    // the output stage refills whenever it is empty or being drained
    assign load     = sel_valid & (~done_valid | done_ready);

    // per-MVU decode of dispatch, acknowledge and output-stage load
    generate
        for (genvar gi = 0; gi < NMVU; gi++) begin : g_dec
            assign start_vec[gi] = pop  & (head_mvu == MIDW'(gi));
            assign hs_vec[gi]    = hs   & (done_mvu == MIDW'(gi));
            assign load_vec[gi]  = load & (sel_idx  == MIDW'(gi));
        end
    endgenerate

    // lowest-index pending completion wins the output stage
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        for (int i = NMVU - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                sel_valid = 1'b1;
                sel_idx   = MIDW'(i);
            end
        end
    end

    // next-state for occupancy, busy and pending sets
    always_comb begin
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count_reg + (AW + 1)'(push) - (AW + 1)'(pop);
        end
        // an acknowledged MVU can never be the one dispatched this cycle
        busy_next    = (busy_reg & ~hs_vec) | start_vec;
        // edges on idle MVUs are only flagged, never queued
        pending_next = (pending_reg & ~load_vec) | (irq_edge & busy_reg);
    end

    // job storage and running-tag capture; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mvu[wr_ptr_reg] <= job_mvu;
            fifo_tag[wr_ptr_reg] <= job_tag;
        end
        if (pop) begin
            tag_r[head_mvu] <= head_tag;
        end
    end

    // control state, start pulses, completion stage and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            job_ready    <= 1'b0;
            busy_reg     <= '0;
            pending_reg  <= '0;
            irq_q_reg    <= '0;
            mvu_start    <= '0;
            done_valid   <= 1'b0;
            done_mvu     <= '0;
            done_tag     <= '0;
            err_badid    <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            if (flush) begin
                rd_ptr_reg <= wr_ptr_reg;
            end else begin
                if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg   <= count_next;
            job_ready   <= (count_next < DEPTH_L);
            busy_reg    <= busy_next;
            pending_reg <= pending_next;
            irq_q_reg   <= mvu_irq;
            mvu_start   <= start_vec;
            if (load) begin
                done_valid <= 1'b1;
                done_mvu   <= sel_idx;
                done_tag   <= tag_r[sel_idx];
            end else if (hs) begin
                done_valid <= 1'b0;
            end
            if (job_acc & ~id_ok)              err_badid    <= 1'b1;
            if (|(irq_edge & ~busy_reg))       err_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mvu_job_scheduler.sv
// Bench for mvu_job_scheduler. Seven MVUs are served so that index 7 is an
// out-of-range id. A job-queue/busy-set reference model is stepped once per
// cycle on the falling edge; directed scenarios run first, then random traffic.
module tb_mvu_job_scheduler;

    localparam int NMVU  = 7;
    localparam int DEPTH = 4;
    localparam int TAGW  = 8;
    localparam int MIDW  = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            job_valid;
    logic            job_ready;
    logic [MIDW-1:0] job_mvu;
    logic [TAGW-1:0] job_tag;
    logic            flush;
    logic [NMVU-1:0] mvu_start;
    logic [NMVU-1:0] mvu_irq;
    logic [NMVU-1:0] mvu_busy;
    logic            done_valid;
    logic            done_ready;
    logic [MIDW-1:0] done_mvu;
    logic [TAGW-1:0] done_tag;
    logic            err_badid;
    logic            err_spurious;

    mvu_job_scheduler #(.NMVU(NMVU), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_mvu(job_mvu), .job_tag(job_tag),
        .flush(flush), .mvu_start(mvu_start), .mvu_irq(mvu_irq), .mvu_busy(mvu_busy),
        .done_valid(done_valid), .done_ready(done_ready), .done_mvu(done_mvu), .done_tag(done_tag),
        .err_badid(err_badid), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state: reflects every clock edge already taken
    int              q_mvu[$];
    int              q_tag[$];
    bit [NMVU-1:0]   busy_m;
    bit [NMVU-1:0]   done_set;
    int              tag_m [8];
    bit              badid_m;
    bit              spur_m;
    logic [NMVU-1:0] exp_start;
    logic [NMVU-1:0] irq_prev;
    // inputs captured for the coming edge
    bit              l_valid, l_ready, l_flush, l_hs;
    int              l_mvu, l_tag, l_hs_mvu;
    logic [NMVU-1:0] l_irq;
    bit              hold_prev;
    int              hold_mvu, hold_tag;
    int              start_log[$];
    int              done_log_mvu[$];
    int              done_log_tag[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp_v, $time);
        end
    endtask

    // one reference-model step, run on each falling edge
    task automatic model_step();
        if (!rst_n) begin
            q_mvu.delete(); q_tag.delete();
            busy_m = '0; done_set = '0; badid_m = 0; spur_m = 0;
            exp_start = '0; irq_prev = '0; l_irq = '0;
            l_valid = 0; l_ready = 0; l_flush = 0; l_hs = 0; hold_prev = 0;
            return;
        end
        // apply what happened at the previous rising edge
        for (int m = 0; m < NMVU; m++) begin
            if (l_irq[m] && !irq_prev[m]) begin
                if (busy_m[m]) done_set[m] = 1'b1;
                else spur_m = 1'b1;
            end
        end
        irq_prev = l_irq;
        if (l_hs) busy_m[l_hs_mvu] = 1'b0;
        if (exp_start != '0) begin
            busy_m[q_mvu[0]] = 1'b1;
            tag_m[q_mvu[0]]  = q_tag[0];
            start_log.push_back(q_mvu[0]);
            void'(q_mvu.pop_front());
            void'(q_tag.pop_front());
        end
        if (l_valid && l_ready && l_mvu >= NMVU) badid_m = 1'b1;
        if (l_flush) begin
            q_mvu.delete(); q_tag.delete();
        end else if (l_valid && l_ready && l_mvu < NMVU) begin
            q_mvu.push_back(l_mvu); q_tag.push_back(l_tag);
        end
        // compare the DUT with the model
        check_eq("start", 32'(mvu_start), 32'(exp_start));
        check_eq("busy", 32'(mvu_busy), 32'(busy_m));
        check_eq("job_ready", 32'(job_ready), 32'(q_mvu.size() < DEPTH));
        check_eq("err_badid", 32'(err_badid), 32'(badid_m));
        check_eq("err_spurious", 32'(err_spurious), 32'(spur_m));
        if (hold_prev) begin
            check_eq("hold_valid", 32'(done_valid), 32'd1);
            check_eq("hold_mvu", 32'(done_mvu), 32'(hold_mvu));
            check_eq("hold_tag", 32'(done_tag), 32'(hold_tag));
        end
        if (done_valid) begin
            check_eq("done_known", 32'(done_set[done_mvu]), 32'd1);
            check_eq("done_tag", 32'(done_tag), 32'(tag_m[done_mvu]));
            if (done_ready) begin
                done_set[done_mvu] = 1'b0;
                done_log_mvu.push_back(int'(done_mvu));
                done_log_tag.push_back(int'(done_tag));
            end
        end
        // capture inputs for the coming edge and predict its dispatch
        l_valid = job_valid; l_ready = job_ready; l_mvu = int'(job_mvu); l_tag = int'(job_tag);
        l_flush = flush; l_irq = mvu_irq;
        l_hs = done_valid & done_ready; l_hs_mvu = int'(done_mvu);
        hold_prev = done_valid & ~done_ready;
        hold_mvu = int'(done_mvu); hold_tag = int'(done_tag);
        exp_start = '0;
        if (q_mvu.size() > 0 && !busy_m[q_mvu[0]] && !flush) exp_start[q_mvu[0]] = 1'b1;
    endtask

    // one cycle: model on the falling edge, then settle just after the rising edge
    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_job(input int m, input int t);
        int n;
        job_mvu = MIDW'(m); job_tag = TAGW'(t); job_valid = 1'b1;
        n = 0;
        while (!job_ready && n < 50) begin
            tick();
            n++;
        end
        check_eq("push_ready", 32'(job_ready), 32'd1);
        tick();
        job_valid = 1'b0;
    endtask

    task automatic irq_pulse(input logic [NMVU-1:0] mask);
        mvu_irq = mask;
        tick();
        mvu_irq = '0;
    endtask

    task automatic accept_one();
        int n;
        done_ready = 1'b1;
        n = 0;
        while (!done_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq("accept_valid", 32'(done_valid), 32'd1);
        tick();
        done_ready = 1'b0;
    endtask

    task automatic clear_inputs();
        job_valid = 0; job_mvu = '0; job_tag = '0; flush = 0; mvu_irq = '0; done_ready = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        model_step();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bs, bd, n;
        logic [NMVU-1:0] elig;
        rst_n = 1'b0;
        clear_inputs();
        repeat (3) tick();
        release_reset();
        check_eq("reset_ready", 32'(job_ready), 32'd1);
        check_eq("reset_done", 32'(done_valid), 32'd0);

        // single job: start at k+1, completion with its tag, busy cleared on accept
        push_job(2, 8'h11);
        check_eq("t1_start_k", 32'(mvu_start), 32'd0);
        tick();
        check_eq("t1_start_k1", 32'(mvu_start), 32'h04);
        check_eq("t1_busy_k1", 32'(mvu_busy), 32'h04);
        tick();
        check_eq("t1_start_k2", 32'(mvu_start), 32'd0);
        irq_pulse(7'h04);
        check_eq("t1_done_j", 32'(done_valid), 32'd0);
        tick();
        check_eq("t1_done_j1", 32'(done_valid), 32'd1);
        check_eq("t1_done_mvu", 32'(done_mvu), 32'd2);
        check_eq("t1_done_tag", 32'(done_tag), 32'h11);
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        check_eq("t1_busy_clr", 32'(mvu_busy), 32'd0);
        check_eq("t1_done_clr", 32'(done_valid), 32'd0);

        // head-of-line: 3, 3, 5
        bs = start_log.size(); bd = done_log_mvu.size();
        push_job(3, 8'hA1); push_job(3, 8'hA2); push_job(5, 8'hA3);
        repeat (4) tick();
        check_eq("t2_busy_stall", 32'(mvu_busy), 32'h08);
        check_eq("t2_starts_stall", 32'(start_log.size() - bs), 32'd1);
        irq_pulse(7'h08);
        accept_one();
        repeat (4) tick();
        check_eq("t2_busy_both", 32'(mvu_busy), 32'h28);
        check_eq("t2_starts", 32'(start_log.size() - bs), 32'd3);
        if (start_log.size() - bs == 3) begin
            check_eq("t2_order1", 32'(start_log[bs + 1]), 32'd3);
            check_eq("t2_order2", 32'(start_log[bs + 2]), 32'd5);
        end
        irq_pulse(7'h28);
        done_ready = 1'b1;
        repeat (5) tick();
        done_ready = 1'b0;
        check_eq("t2_dones", 32'(done_log_mvu.size() - bd), 32'd3);
        if (done_log_mvu.size() - bd == 3) begin
            check_eq("t2_d1_tag", 32'(done_log_tag[bd]), 32'hA1);
            check_eq("t2_d2_mvu", 32'(done_log_mvu[bd + 1]), 32'd3);
            check_eq("t2_d2_tag", 32'(done_log_tag[bd + 1]), 32'hA2);
            check_eq("t2_d3_mvu", 32'(done_log_mvu[bd + 2]), 32'd5);
            check_eq("t2_d3_tag", 32'(done_log_tag[bd + 2]), 32'hA3);
        end

        // simultaneous completions report in ascending order, one per cycle
        push_job(1, 8'hB1); push_job(4, 8'hB4); push_job(6, 8'hB6);
        repeat (4) tick();
        check_eq("t3_busy", 32'(mvu_busy), 32'h52);
        done_ready = 1'b1;
        irq_pulse(7'h52);
        check_eq("t3_done_j", 32'(done_valid), 32'd0);
        tick();
        check_eq("t3_c1_mvu", 32'(done_mvu), 32'd1);
        check_eq("t3_c1_tag", 32'(done_tag), 32'hB1);
        tick();
        check_eq("t3_c2_mvu", 32'(done_mvu), 32'd4);
        check_eq("t3_c2_tag", 32'(done_tag), 32'hB4);
        tick();
        check_eq("t3_c3_valid", 32'(done_valid), 32'd1);
        check_eq("t3_c3_mvu", 32'(done_mvu), 32'd6);
        check_eq("t3_c3_tag", 32'(done_tag), 32'hB6);
        tick();
        check_eq("t3_drained", 32'(done_valid), 32'd0);
        done_ready = 1'b0;

        // fill behind a busy MVU, then flush
        push_job(0, 8'hC0);
        repeat (2) tick();
        for (int i = 1; i <= DEPTH; i++) push_job(0, 8'hC0 + i);
        check_eq("t4_full", 32'(job_ready), 32'd0);
        bs = start_log.size();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("t4_ready", 32'(job_ready), 32'd1);
        repeat (4) tick();
        irq_pulse(7'h01);
        accept_one();
        check_eq("t4_tag", 32'(done_log_tag[done_log_tag.size() - 1]), 32'hC0);
        repeat (3) tick();
        check_eq("t4_no_start", 32'(start_log.size() - bs), 32'd0);
        check_eq("t4_idle", 32'(mvu_busy), 32'd0);

        // bad id and spurious irq
        push_job(7, 8'hE0);
        tick();
        check_eq("t5_badid", 32'(err_badid), 32'd1);
        check_eq("t5_busy", 32'(mvu_busy), 32'd0);
        irq_pulse(7'h04);
        check_eq("t5_spurious", 32'(err_spurious), 32'd1);
        tick();
        check_eq("t5_no_done", 32'(done_valid), 32'd0);

        // reset while a completion is being held
        push_job(2, 8'hD1);
        repeat (3) tick();
        irq_pulse(7'h04);
        repeat (2) tick();
        check_eq("t6_held", 32'(done_valid), 32'd1);
        rst_n = 1'b0;
        clear_inputs();
        #1;
        check_eq("t6_r_valid", 32'(done_valid), 32'd0);
        check_eq("t6_r_mvu", 32'(done_mvu), 32'd0);
        check_eq("t6_r_tag", 32'(done_tag), 32'd0);
        check_eq("t6_r_busy", 32'(mvu_busy), 32'd0);
        check_eq("t6_r_start", 32'(mvu_start), 32'd0);
        check_eq("t6_r_ready", 32'(job_ready), 32'd0);
        check_eq("t6_r_badid", 32'(err_badid), 32'd0);
        check_eq("t6_r_spur", 32'(err_spurious), 32'd0);
        release_reset();
        push_job(5, 8'hF1);
        check_eq("t6_start_k", 32'(mvu_start), 32'd0);
        tick();
        check_eq("t6_start_k1", 32'(mvu_start), 32'h20);

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            job_valid  = ($urandom_range(0, 2) == 0);
            job_mvu    = MIDW'($urandom_range(0, 7));
            job_tag    = TAGW'($urandom);
            flush      = ($urandom_range(0, 49) == 0);
            done_ready = $urandom_range(0, 1) == 1;
            elig = busy_m & ~done_set & ~mvu_irq;
            mvu_irq = elig & NMVU'($urandom) & NMVU'($urandom);
            tick();
        end

        // drain everything that is still queued or running
        job_valid = 0; flush = 0; done_ready = 1;
        n = 0;
        while ((q_mvu.size() != 0 || busy_m != '0 || done_set != '0) && n < 500) begin
            elig = busy_m & ~done_set & ~mvu_irq;
            mvu_irq = elig;
            tick();
            n++;
        end
        mvu_irq = '0;
        repeat (3) tick();
        check_eq("drain_busy", 32'(mvu_busy), 32'd0);
        check_eq("drain_done", 32'(done_valid), 32'd0);
        check_eq("drain_queue", 32'(q_mvu.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
